// File: rtl/ir_decoder_if.sv
// Handshake bundle between the NEC IR decoder and its command consumer.
interface ir_decoder_if;
    logic        ready;
    logic [31:0] cmd;
    logic        valid;
    logic        repeat_pulse;
    logic        err;

    modport master (
        input  ready,
        output cmd,
        output valid,
        output repeat_pulse,
        output err
    );

    modport slave (
        output ready,
        input  cmd,
        input  valid,
        input  repeat_pulse,
        input  err
    );
endinterface

// File: rtl/ir_decoder.sv
// NEC IR receiver: times mark/space durations from a demodulated pin,
// assembles the 32-bit frame and hands it over on a valid/ready handshake.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | waiting for the leading mark to start
// LEAD_MARK  | timing the 9 ms leading mark
// LEAD_SPACE | timing the space after the lead (frame or repeat code)
// BIT_MARK   | timing the 562.5 us mark that opens every data bit
// BIT_SPACE  | timing the data space; its length carries the bit value
// STOP_MARK  | timing the final mark; frame delivered when it ends
// RPT_STOP   | timing the stop mark of a repeat code
module ir_decoder #(
    parameter int TICK_DIV      = 1406,
    parameter bit IN_ACTIVE_LOW = 1'b1,
    parameter bit CHECK_INV     = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ir_input,
    ir_decoder_if.master    bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, RPT_STOP
    } state_t;

    state_t        state;
    logic [1:0]    sync_q;
    logic          mark_q;
    logic          mark_prev;
    logic [PW-1:0] pre;
    logic [7:0]    dur;
    logic [4:0]    bit_cnt;
    logic [31:0]   sh;
    logic          last_ok;

    logic rise, fall, edge_any, tick, timeout;

    function automatic logic in_win(input logic [7:0] d, input logic [7:0] lo,
                                    input logic [7:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

    assign rise     = mark_q & ~mark_prev;
    assign fall     = ~mark_q & mark_prev;
    assign edge_any = rise | fall;
    assign tick     = (pre == PW'(TICK_DIV - 1));
    assign timeout  = (state != IDLE) && (dur == 8'hFF);

    // Synchronise the pin and normalise it so that mark = 1; the synchroniser
    // resets to the idle pin level so reset release never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= {2{IN_ACTIVE_LOW}};
            mark_q    <= 1'b0;
            mark_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], ir_input};
            mark_q    <= IN_ACTIVE_LOW ? ~sync_q[1] : sync_q[1];
            mark_prev <= mark_q;
        end
    end

    // Tick prescaler and saturating duration counter, restarted on every edge.
    always_ff @(posedge clk) begin
        if (rst || edge_any) begin
            pre <= '0;
            dur <= '0;
        end else if (tick) begin
            pre <= '0;
            if (dur != 8'hFF)
                dur <= dur + 8'd1;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    // Frame FSM with registered handshake, repeat and error outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            bit_cnt          <= '0;
            sh               <= '0;
            last_ok          <= 1'b0;
            bus.cmd          <= '0;
            bus.valid        <= 1'b0;
            bus.repeat_pulse <= 1'b0;
            bus.err          <= 1'b0;
        end else begin
            bus.repeat_pulse <= 1'b0;
            bus.err          <= 1'b0;
            if (bus.valid && bus.ready)
                bus.valid <= 1'b0;

            if (timeout) begin
                bus.err <= 1'b1;
                last_ok <= 1'b0;
                state   <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise)
                            state <= LEAD_MARK;
                    end
                    LEAD_MARK: begin
                        if (fall) begin
                            if (in_win(dur, 8'd128, 8'd192)) begin
                                state <= LEAD_SPACE;
                            end else begin
                                bus.err <= 1'b1;
                                last_ok <= 1'b0;
                                state   <= IDLE;
                            end
                        end
                    end
                    LEAD_SPACE: begin
                        if (rise) begin
                            if (in_win(dur, 8'd64, 8'd96)) begin
                                bit_cnt <= '0;
                                state   <= BIT_MARK;
                            end else if (in_win(dur, 8'd32, 8'd48)) begin
                                state <= RPT_STOP;
                            end else begin
                                bus.err <= 1'b1;
                                last_ok <= 1'b0;
                                state   <= IDLE;
                            end
                        end
                    end
                    BIT_MARK: begin
                        if (fall) begin
                            if (in_win(dur, 8'd5, 8'd15)) begin
                                state <= BIT_SPACE;
                            end else begin
                                bus.err <= 1'b1;
                                last_ok <= 1'b0;
                                state   <= IDLE;
                            end
                        end
                    end
                    BIT_SPACE: begin
                        if (rise) begin
                            if (in_win(dur, 8'd5, 8'd15) || in_win(dur, 8'd20, 8'd40)) begin
                                sh[bit_cnt] <= in_win(dur, 8'd20, 8'd40);
                                if (bit_cnt == 5'd31) begin
                                    state <= STOP_MARK;
                                end else begin
                                    bit_cnt <= bit_cnt + 5'd1;
                                    state   <= BIT_MARK;
                                end
                            end else begin
                                bus.err <= 1'b1;
                                last_ok <= 1'b0;
                                state   <= IDLE;
                            end
                        end
                    end
                    STOP_MARK: begin
                        if (fall) begin
                            state <= IDLE;
                            if (!in_win(dur, 8'd5, 8'd15)) begin
                                bus.err <= 1'b1;
                                last_ok <= 1'b0;
                            end else if (CHECK_INV && (sh[31:24] != ~sh[23:16])) begin
                                bus.err <= 1'b1;
                                last_ok <= 1'b0;
                            end else if (bus.valid && !bus.ready) begin
                                // Overrun: the unconsumed frame wins, the new one is dropped.
                                bus.err <= 1'b1;
                                last_ok <= 1'b0;
                            end else begin
                                bus.cmd   <= sh;
                                bus.valid <= 1'b1;
                                last_ok   <= 1'b1;
                            end
                        end
                    end
                    RPT_STOP: begin
                        if (fall) begin
                            state <= IDLE;
                            if (!in_win(dur, 8'd5, 8'd15)) begin
                                bus.err <= 1'b1;
                                last_ok <= 1'b0;
                            end else if (last_ok) begin
                                bus.repeat_pulse <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ir_decoder.sv
// Scoreboard bench for the NEC IR decoder running with a 4-cycle tick.
module tb_ir_decoder;

    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ir_input = 1'b1;

    ir_decoder_if bus_if ();

    ir_decoder #(.TICK_DIV(TD), .IN_ACTIVE_LOW(1'b1), .CHECK_INV(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .ir_input (ir_input),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_cmd[$];
    int          exp_rpt = 0;
    int          exp_err = 0;

    localparam logic [31:0] FRAME_A   = 32'hED120707;
    localparam logic [31:0] FRAME_BAD = 32'hEC120707;
    localparam logic [31:0] FRAME_B   = 32'hFE0100FF;

    // Monitor: every accepted frame, repeat pulse and error pulse is matched
    // against what the stimulus side queued.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_if.valid && bus_if.ready) begin
                checks++;
                if (exp_cmd.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_cmd got=%h expected=none", bus_if.cmd);
                end else begin
                    logic [31:0] e;
                    e = exp_cmd.pop_front();
                    if (bus_if.cmd !== e) begin
                        failures++;
                        $display("FAIL cmd got=%h expected=%h", bus_if.cmd, e);
                    end
                end
            end
            if (bus_if.repeat_pulse) begin
                checks++;
                if (exp_rpt == 0) begin
                    failures++;
                    $display("FAIL unexpected_repeat got=1 expected=0");
                end else begin
                    exp_rpt--;
                end
            end
            if (bus_if.err) begin
                checks++;
                if (exp_err == 0) begin
                    failures++;
                    $display("FAIL unexpected_err got=1 expected=0");
                end else begin
                    exp_err--;
                end
            end
        end
    end

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    task automatic drain(input string name, input int pend_cmd);
        checks++;
        if (exp_cmd.size() != pend_cmd || exp_rpt != 0 || exp_err != 0) begin
            failures++;
            $display("FAIL %s pending cmd=%0d rpt=%0d err=%0d expected cmd=%0d rpt=0 err=0",
                     name, exp_cmd.size(), exp_rpt, exp_err, pend_cmd);
        end
    endtask

    task automatic hold(input logic level, input int ticks);
        ir_input = level;
        repeat (ticks * TD) @(posedge clk);
        #1;
    endtask

    task automatic mark(input int ticks);
        hold(1'b0, ticks);
    endtask

    task automatic space(input int ticks);
        hold(1'b1, ticks);
    endtask

    task automatic send_bits(input logic [31:0] f, input int nbits);
        mark(160);
        space(80);
        for (int i = 0; i < nbits; i++) begin
            mark(10);
            space(f[i] ? 30 : 10);
        end
    endtask

    task automatic send_frame(input logic [31:0] f);
        send_bits(f, 32);
        mark(10);
        space(40);
    endtask

    task automatic send_repeat();
        mark(160);
        space(40);
        mark(10);
        space(40);
    endtask

    task automatic do_reset();
        ir_input = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check32({tag, "_cmd"}, bus_if.cmd, 32'h0);
        check32({tag, "_valid"}, {31'b0, bus_if.valid}, 32'h0);
        check32({tag, "_rpt"}, {31'b0, bus_if.repeat_pulse}, 32'h0);
        check32({tag, "_err"}, {31'b0, bus_if.err}, 32'h0);
    endtask

    initial begin
        bus_if.ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset();
        check_outputs_zero("reset");

        // Repeat code with no prior frame: silently ignored.
        send_repeat();
        space(20);
        drain("repeat_no_frame", 0);

        // Good frame consumed immediately.
        exp_cmd.push_back(FRAME_A);
        send_frame(FRAME_A);
        space(20);
        drain("frame_a", 0);
        check32("valid_after_accept", {31'b0, bus_if.valid}, 32'h0);

        // Repeat code after a good frame: one pulse, cmd kept.
        exp_rpt = 1;
        send_repeat();
        space(20);
        drain("repeat_after_frame", 0);
        check32("cmd_after_repeat", bus_if.cmd, FRAME_A);

        // Command byte does not match its inverse.
        exp_err = 1;
        send_frame(FRAME_BAD);
        space(20);
        drain("bad_inverse", 0);
        check32("valid_bad_inverse", {31'b0, bus_if.valid}, 32'h0);
        check32("cmd_bad_inverse", bus_if.cmd, FRAME_A);

        // Repeat right after a rejected frame is not honoured.
        send_repeat();
        space(20);
        drain("repeat_after_err", 0);

        // Lead mark far too short.
        exp_err = 1;
        mark(100);
        space(100);
        drain("short_lead", 0);

        // Mark stuck for 300 ticks mid-frame: timeout.
        exp_err = 1;
        mark(160);
        space(80);
        mark(300);
        space(60);
        drain("stuck_mark", 0);

        // Consumer stalled: first frame held, second frame is an overrun.
        bus_if.ready = 1'b0;
        exp_cmd.push_back(FRAME_A);
        send_frame(FRAME_A);
        space(20);
        check32("held_valid", {31'b0, bus_if.valid}, 32'h1);
        check32("held_cmd", bus_if.cmd, FRAME_A);
        exp_err = 1;
        send_frame(FRAME_B);
        space(20);
        drain("overrun", 1);
        check32("overrun_valid", {31'b0, bus_if.valid}, 32'h1);
        check32("overrun_cmd", bus_if.cmd, FRAME_A);

        // Reset in the middle of a frame discards everything, pending frame included.
        send_bits(FRAME_B, 16);
        exp_cmd.delete();
        do_reset();
        check_outputs_zero("mid_reset");
        bus_if.ready = 1'b1;
        space(60);
        drain("after_reset", 0);

        // Decoder still works after the abort.
        exp_cmd.push_back(FRAME_B);
        send_frame(FRAME_B);
        space(20);
        drain("frame_b", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
